// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and range helper for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int CNT_W = 4;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  // 33-bit compare so a segment ending at the top of the address space cannot wrap
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned depth_words);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + (33'(depth_words) << 2);
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous data RAM with registered read
module dmem_array #(
  parameter int DATAWIDTH   = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [DATAWIDTH-1:0]           wdata,
  output logic [DATAWIDTH-1:0]           rdata
);

  logic [DATAWIDTH-1:0] mem [DEPTH_WORDS];

  // Write when enabled; read data is registered every cycle from the same address
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with wait states; DMEM_MISALIGN_CHECK_EN faults unaligned addresses
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DATAWIDTH   = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          dAddress,
  input  logic [DATAWIDTH-1:0] dWriteData,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATAWIDTH-1:0] dReadData,
  output logic                 resp_err,
  output logic                 busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [31:0]          addr_q;
  logic [DATAWIDTH-1:0] wdata_q;
  logic                 we_q;

  logic [31:0]          ram_byte_addr;
  logic [AW-1:0]        ram_addr;
  logic                 ram_we;
  logic [DATAWIDTH-1:0] ram_rdata;
  logic                 fault;

  // In IDLE the RAM is addressed from the incoming request so a zero-wait load has its data by ACCESS
  always_comb begin
    ram_byte_addr = (state == IDLE) ? dAddress : addr_q;
    ram_addr      = AW'((ram_byte_addr - BASE_ADDR) >> 2);
`ifdef DMEM_MISALIGN_CHECK_EN
    fault         = !addr_in_range(addr_q, BASE_ADDR, DEPTH_WORDS) || (addr_q[1:0] != 2'b00);
`else
    fault         = !addr_in_range(addr_q, BASE_ADDR, DEPTH_WORDS);
`endif
    ram_we        = (state == ACCESS) && we_q && !fault;
  end

  dmem_array #(
    .DATAWIDTH   (DATAWIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Request/response FSM; every output is a register updated here
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      dReadData  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= dAddress;
            wdata_q   <= dWriteData;
            we_q      <= req_we;
            cnt       <= CNT_W'(WAIT_CYCLES);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= ACCESS;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACCESS: begin
          resp_valid <= 1'b1;
          resp_err   <= fault;
          dReadData  <= (fault || we_q) ? '0 : ram_rdata;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
